// File: rtl/ram_arb_pkg.sv
// Shared types for the two-port RAM arbiter.
// Owner states, port ids and read-return tags.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } owner_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

    typedef struct packed {
        logic valid;
        logic id;
    } rd_tag_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Read-return tag shift register.
// Carries {valid,id} from accept until RAM data is due.
module rd_tag_pipe
    import ram_arb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic in_id,
    output logic out_valid,
    output logic out_id
);

    rd_tag_t pipe [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= '{valid: in_valid, id: in_id};
            for (int i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign out_valid = pipe[DEPTH-1].valid;
    assign out_id    = pipe[DEPTH-1].id;

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one RAM
// between the CPU (port 0) and the loader (port 1).
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int RD_LAT    = 1,
    parameter int MAX_BURST = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          cpu_stall,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);
    localparam logic [CW-1:0] ONE     = CW'(1);

    owner_t        state, state_nx;
    logic          last, last_nx;
    logic [CW-1:0] burst_cnt, burst_nx;
    logic          tag_valid, tag_id;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state)
            OWN0: begin
                if (req0 && (!req1 || burst_cnt < MAX_CNT)) gnt0 = 1'b1;
                else if (req1) gnt1 = 1'b1;
            end
            OWN1: begin
                if (req1 && (!req0 || burst_cnt < MAX_CNT)) gnt1 = 1'b1;
                else if (req0) gnt0 = 1'b1;
            end
            default: begin
                if (req0 && req1) begin
                    gnt0 = (last != PORT_CPU);
                    gnt1 = (last == PORT_CPU);
                end else begin
                    gnt0 = req0;
                    gnt1 = req1;
                end
            end
        endcase
        if (rst) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    always_comb begin
        state_nx = state;
        last_nx  = last;
        burst_nx = burst_cnt;
        if (gnt0) begin
            if (state == OWN0) begin
                if (burst_cnt != MAX_CNT) burst_nx = burst_cnt + ONE;
            end else begin
                state_nx = OWN0;
                burst_nx = ONE;
                last_nx  = PORT_CPU;
            end
        end else if (gnt1) begin
            if (state == OWN1) begin
                if (burst_cnt != MAX_CNT) burst_nx = burst_cnt + ONE;
            end else begin
                state_nx = OWN1;
                burst_nx = ONE;
                last_nx  = PORT_LDR;
            end
        end else if (state != IDLE) begin
            state_nx = IDLE;
            burst_nx = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            last      <= PORT_LDR;
            burst_cnt <= '0;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            state     <= state_nx;
            last      <= last_nx;
            burst_cnt <= burst_nx;
            ram_en    <= gnt0 | gnt1;
            ram_we    <= (gnt0 & we0) | (gnt1 & we1);
            if (gnt0) begin
                ram_addr  <= addr0;
                ram_wdata <= wdata0;
            end else if (gnt1) begin
                ram_addr  <= addr1;
                ram_wdata <= wdata1;
            end
        end
    end

    rd_tag_pipe #(
        .DEPTH(RD_LAT + 1)
    ) u_tags (
        .clk      (clk),
        .rst      (rst),
        .in_valid ((gnt0 & ~we0) | (gnt1 & ~we1)),
        .in_id    (gnt1 ? PORT_LDR : PORT_CPU),
        .out_valid(tag_valid),
        .out_id   (tag_id)
    );

    assign rvalid0   = tag_valid & (tag_id == PORT_CPU);
    assign rvalid1   = tag_valid & (tag_id == PORT_LDR);
    assign rdata     = tag_valid ? ram_rdata : '0;
    assign cpu_stall = req0 & ~gnt0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios plus
// random traffic against a transaction-level model.
module tb_ram_port_arbiter;

    localparam int RD_LAT    = 1;
    localparam int MAX_BURST = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0;
    logic       we0 = 1'b0, we1 = 1'b0;
    logic [7:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic       gnt0, gnt1, rvalid0, rvalid1, cpu_stall;
    logic       ram_en, ram_we;
    logic [7:0] rdata, ram_addr, ram_wdata, ram_rdata;

    ram_port_arbiter #(
        .AW(8), .DW(8), .RD_LAT(RD_LAT), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1),
        .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .cpu_stall(cpu_stall),
        .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    // External RAM with RD_LAT cycles of read latency
    logic [7:0] ram [256];
    logic [7:0] rpipe [RD_LAT];
    always @(posedge clk) begin
        if (ram_en && ram_we) ram[ram_addr] <= ram_wdata;
        if (ram_en && !ram_we) rpipe[0] <= ram[ram_addr];
        for (int i = 1; i < RD_LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign ram_rdata = rpipe[RD_LAT-1];

    // Transaction-level model
    typedef struct {
        int         due;
        int         port;
        logic [7:0] data;
    } rd_exp_t;

    rd_exp_t    rq[$];
    logic [7:0] mem_m [256];
    int         owner = -1;
    int         tenure = 0;
    int         last = 1;
    int         cyc = 0;
    int         exp_w;
    logic       exp_rv0, exp_rv1;
    logic [7:0] exp_rd;
    logic       cur_en = 1'b0, cur_we = 1'b0;
    logic [7:0] cur_addr = '0, cur_wdata = '0;

    int errors = 0;
    int checks = 0;

    function automatic int model_winner();
        int   x, y;
        logic rx, ry;
        if (rst) return -1;
        if (owner < 0) begin
            if (req0 && req1) return 1 - last;
            if (req0) return 0;
            if (req1) return 1;
            return -1;
        end
        x  = owner;
        y  = 1 - owner;
        rx = (x == 0) ? req0 : req1;
        ry = (y == 0) ? req0 : req1;
        if (rx && (!ry || tenure < MAX_BURST)) return x;
        if (ry) return y;
        return -1;
    endfunction

    task automatic settle();
        exp_w   = model_winner();
        exp_rv0 = 1'b0;
        exp_rv1 = 1'b0;
        exp_rd  = '0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            if (rq[0].port == 0) exp_rv0 = 1'b1;
            else exp_rv1 = 1'b1;
            exp_rd = rq[0].data;
        end
        #1;
    endtask

    task automatic advance();
        logic       w_we;
        logic [7:0] w_addr, w_data;
        if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
        if (rst) begin
            owner = -1; tenure = 0; last = 1;
            rq.delete();
            cur_en = 0; cur_we = 0; cur_addr = '0; cur_wdata = '0;
        end else if (exp_w >= 0) begin
            if (exp_w == owner) begin
                if (tenure < MAX_BURST) tenure++;
            end else begin
                owner = exp_w; tenure = 1; last = exp_w;
            end
            w_we   = (exp_w == 0) ? we0 : we1;
            w_addr = (exp_w == 0) ? addr0 : addr1;
            w_data = (exp_w == 0) ? wdata0 : wdata1;
            cur_en = 1; cur_we = w_we;
            cur_addr = w_addr; cur_wdata = w_data;
            if (w_we) mem_m[w_addr] = w_data;
            else rq.push_back('{cyc + 1 + RD_LAT, exp_w, mem_m[w_addr]});
        end else begin
            cur_en = 0; cur_we = 0;
            owner = -1; tenure = 0;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic no_req();
        req0 = 0; req1 = 0;
    endtask

    task automatic test_reset();
        rst = 1; req0 = 1; req1 = 1;
        for (int i = 0; i < 3; i++) begin
            settle();
            checks++;
            if ({gnt0, gnt1} !== 2'b00) begin
                errors++;
                $display("FAIL reset_gnt: got %b%b want 00", gnt0, gnt1);
            end
            checks++;
            if (cpu_stall !== 1'b1) begin
                errors++;
                $display("FAIL reset_stall: got %b want 1", cpu_stall);
            end
            checks++;
            if (ram_en !== 1'b0 || {rvalid0, rvalid1} !== 2'b00) begin
                errors++;
                $display("FAIL reset_out: en=%b rv=%b%b want 0 00",
                         ram_en, rvalid0, rvalid1);
            end
            advance();
        end
        rst = 0;
    endtask

    task automatic test_burst_rr();
        int want;
        req0 = 1; req1 = 1; we0 = 1; we1 = 1;
        for (int i = 0; i < 12; i++) begin
            addr0 = 8'h80 + 8'(i); wdata0 = 8'(i);
            addr1 = 8'hC0 + 8'(i); wdata1 = 8'(i);
            want = (i / 4) % 2;
            settle();
            checks++;
            if (gnt0 !== (want == 0) || gnt1 !== (want == 1)) begin
                errors++;
                $display("FAIL burst_rr[%0d]: got %b%b want port %0d",
                         i, gnt0, gnt1, want);
            end
            advance();
        end
        no_req(); we0 = 0; we1 = 0;
        settle(); advance();
    endtask

    task automatic test_cpu_read();
        req0 = 1; we0 = 0; addr0 = 8'h12;
        settle();
        checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            errors++;
            $display("FAIL cpu_read_gnt: got %b%b want 10", gnt0, gnt1);
        end
        advance();
        req0 = 0;
        settle();
        checks++;
        if (ram_en !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 8'h12) begin
            errors++;
            $display("FAIL cpu_read_cmd: en=%b we=%b a=%h want 1 0 12",
                     ram_en, ram_we, ram_addr);
        end
        advance();
        settle();
        checks++;
        if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata !== 8'hA5) begin
            errors++;
            $display("FAIL cpu_read_ret: rv=%b%b d=%h want 10 a5",
                     rvalid0, rvalid1, rdata);
        end
        advance();
    endtask

    task automatic test_back_to_back();
        req1 = 1; we1 = 1; addr1 = 8'h40; wdata1 = 8'h3C;
        settle();
        checks++;
        if (gnt1 !== 1'b1) begin
            errors++;
            $display("FAIL raw_wr_gnt: got %b want 1", gnt1);
        end
        advance();
        req1 = 0; req0 = 1; we0 = 0; addr0 = 8'h40;
        settle();
        checks++;
        if (gnt0 !== 1'b1) begin
            errors++;
            $display("FAIL raw_rd_gnt: got %b want 1", gnt0);
        end
        advance();
        req0 = 0;
        for (int k = 0; k < 4; k++) begin
            settle();
            checks++;
            if (rvalid0 !== (k == 1) || rvalid1 !== 1'b0) begin
                errors++;
                $display("FAIL raw_rvalid[%0d]: got %b%b want %b0",
                         k, rvalid0, rvalid1, k == 1);
            end
            if (k == 1) begin
                checks++;
                if (rdata !== 8'h3C) begin
                    errors++;
                    $display("FAIL raw_data: got %h want 3c", rdata);
                end
            end
            advance();
        end
    endtask

    task automatic test_stall();
        int stalls;
        stalls = 0;
        req1 = 1; we1 = 1; addr1 = 8'h20; wdata1 = 8'h11;
        settle(); advance();
        req0 = 1; we0 = 1; addr0 = 8'h21; wdata0 = 8'h22;
        for (int i = 0; i < 6 && !gnt0; i++) begin
            settle();
            if (cpu_stall === 1'b1) stalls++;
            if (gnt0 !== 1'b1) advance();
        end
        checks++;
        if (stalls !== 3 || gnt0 !== 1'b1) begin
            errors++;
            $display("FAIL stall_len: got %0d gnt0=%b want 3 1",
                     stalls, gnt0);
        end
        advance();
        no_req();
        settle(); advance();
    endtask

    task automatic test_reset_midread();
        req0 = 1; we0 = 0; addr0 = 8'h12;
        settle(); advance();
        req0 = 0; rst = 1;
        settle(); advance();
        rst = 0;
        for (int k = 0; k < 3; k++) begin
            settle();
            checks++;
            if (rvalid0 !== 1'b0 || (k == 0 && ram_en !== 1'b0)) begin
                errors++;
                $display("FAIL midrst[%0d]: rv0=%b en=%b want 0 0",
                         k, rvalid0, ram_en);
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic pend0, pend1;
        pend0 = 0; pend1 = 0;
        for (int n = 0; n < 600; n++) begin
            if (!pend0 && $urandom_range(2) == 0) begin
                pend0 = 1; we0 = 1'($urandom);
                addr0 = 8'($urandom_range(15)); wdata0 = 8'($urandom);
            end else if (pend0 && $urandom_range(15) == 0) pend0 = 0;
            if (!pend1 && $urandom_range(2) == 0) begin
                pend1 = 1; we1 = 1'($urandom);
                addr1 = 8'($urandom_range(15)); wdata1 = 8'($urandom);
            end else if (pend1 && $urandom_range(15) == 0) pend1 = 0;
            req0 = pend0; req1 = pend1;
            rst  = ($urandom_range(79) == 0);
            settle();
            checks++;
            if (gnt0 !== (exp_w == 0) || gnt1 !== (exp_w == 1)) begin
                errors++;
                $display("FAIL rnd_gnt@%0d: got %b%b want %0d",
                         cyc, gnt0, gnt1, exp_w);
            end
            checks++;
            if (cpu_stall !== (req0 && exp_w != 0)) begin
                errors++;
                $display("FAIL rnd_stall@%0d: got %b", cyc, cpu_stall);
            end
            checks++;
            if ({ram_en, ram_we, ram_addr, ram_wdata} !==
                {cur_en, cur_we, cur_addr, cur_wdata}) begin
                errors++;
                $display("FAIL rnd_cmd@%0d: got %b%b %h %h want %b%b %h %h",
                         cyc, ram_en, ram_we, ram_addr, ram_wdata,
                         cur_en, cur_we, cur_addr, cur_wdata);
            end
            checks++;
            if (rvalid0 !== exp_rv0 || rvalid1 !== exp_rv1) begin
                errors++;
                $display("FAIL rnd_rvalid@%0d: got %b%b want %b%b",
                         cyc, rvalid0, rvalid1, exp_rv0, exp_rv1);
            end
            if (exp_rv0 || exp_rv1) begin
                checks++;
                if (rdata !== exp_rd) begin
                    errors++;
                    $display("FAIL rnd_rdata@%0d: got %h want %h",
                             cyc, rdata, exp_rd);
                end
            end
            if (exp_w == 0) pend0 = 0;
            if (exp_w == 1) pend1 = 0;
            advance();
        end
        rst = 0; no_req();
        settle(); advance();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]   = 8'(i) ^ 8'h5A;
            mem_m[i] = 8'(i) ^ 8'h5A;
        end
        ram[8'h12]   = 8'hA5;
        mem_m[8'h12] = 8'hA5;
        @(negedge clk);
        test_reset();
        test_burst_rr();
        test_cpu_read();
        test_back_to_back();
        test_stall();
        test_reset_midread();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
